// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - SRAM-like multi-port to single AXI3 master bridge
module cpu_axi_bridge #(
  parameter int NPORT   = 2,
  parameter int ID_W    = 4,
  parameter int RD_OUTS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NPORT-1:0]      s_req,
  input  logic [NPORT-1:0]      s_wr,
  input  logic [2*NPORT-1:0]    s_size,
  input  logic [4*NPORT-1:0]    s_wstrb,
  input  logic [32*NPORT-1:0]   s_addr,
  input  logic [32*NPORT-1:0]   s_wdata,
  output logic [NPORT-1:0]      s_addr_ok,
  output logic [NPORT-1:0]      s_data_ok,
  output logic [31:0]           s_rdata,
  output logic [ID_W-1:0]       arid,
  output logic [31:0]           araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ID_W-1:0]       awid,
  output logic [31:0]           awaddr,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_W-1:0]       wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(RD_OUTS + 1);

  typedef enum logic {AR_IDLE, AR_VALID} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  ar_state_t         ar_state;
  w_state_t          w_state;
  logic [CW-1:0]     cnt [NPORT];
  logic              cnt_zero;
  logic [NPORT-1:0]  elig;
  logic [NPORT-1:0]  rd_hit;
  logic [NPORT-1:0]  rd_inc;
  logic              gnt_valid;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_wr;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;
  logic [1:0]        sel_size;
  logic              wr_done;
  logic              unused_inputs;

  // Response status, last flags and bid carry no information for single-beat traffic
  assign unused_inputs = ^{rresp, rlast, bresp, bid};

  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wlast   = 1'b1;
  assign s_rdata = rdata;

  // Writes may only start once every port has drained its reads
  always_comb begin
    cnt_zero = 1'b1;
    for (int p = 0; p < NPORT; p++) begin
      if (cnt[p] != '0) cnt_zero = 1'b0;
    end
  end

  // Eligibility; rready doubles as the out-of-reset flag so no grant is made in reset
  always_comb begin
    elig = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (rready && ar_state == AR_IDLE && w_state == W_IDLE) begin
        elig[p] = s_wr[p] ? cnt_zero : (cnt[p] < CW'(RD_OUTS));
      end
    end
  end

  // Fixed-priority arbiter: later (higher-index) ports override earlier ones
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_size  = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (s_req[p] && elig[p]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PW'(p);
        sel_addr  = s_addr[32*p +: 32];
        sel_wdata = s_wdata[32*p +: 32];
        sel_wstrb = s_wstrb[4*p +: 4];
        sel_size  = s_size[2*p +: 2];
      end
    end
  end

  // One-hot accept, per-port read issue/return strobes and data_ok merge
  always_comb begin
    s_addr_ok = '0;
    rd_inc    = '0;
    rd_hit    = '0;
    s_data_ok = '0;
    gnt_wr    = gnt_valid && s_wr[gnt_idx];
    for (int p = 0; p < NPORT; p++) begin
      s_addr_ok[p] = gnt_valid && (gnt_idx == PW'(p));
      rd_inc[p]    = s_addr_ok[p] && !s_wr[p];
      rd_hit[p]    = rready && rvalid && (rid == ID_W'(p));
      s_data_ok[p] = rd_hit[p] || (wr_done && awid == ID_W'(p));
    end
  end

  // Out-of-reset flag; reads are always accepted once running
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rready <= 1'b0;
    else         rready <= 1'b1;
  end

  // Outstanding-read counters; simultaneous issue and return cancel out
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < NPORT; p++) cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (rd_inc[p] && !rd_hit[p])      cnt[p] <= cnt[p] + CW'(1);
        else if (!rd_inc[p] && rd_hit[p]) cnt[p] <= cnt[p] - CW'(1);
      end
    end
  end

  // Read address FSM: hold one AR beat until arready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
      arid     <= '0;
      araddr   <= '0;
      arsize   <= '0;
    end else begin
      unique case (ar_state)
        AR_IDLE: begin
          if (gnt_valid && !gnt_wr) begin
            ar_state <= AR_VALID;
            arvalid  <= 1'b1;
            arid     <= ID_W'(gnt_idx);
            araddr   <= sel_addr;
            arsize   <= {1'b0, sel_size};
          end
        end
        AR_VALID: begin
          if (arready) begin
            ar_state <= AR_IDLE;
            arvalid  <= 1'b0;
          end
        end
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  // Write FSM: AW and W retire independently, then wait for B; completion reported a cycle after bvalid
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      wr_done <= 1'b0;
      awid    <= '0;
      wid     <= '0;
      awaddr  <= '0;
      awsize  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else begin
      wr_done <= 1'b0;
      unique case (w_state)
        W_IDLE: begin
          if (gnt_wr) begin
            w_state <= W_SEND;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awid    <= ID_W'(gnt_idx);
            wid     <= ID_W'(gnt_idx);
            awaddr  <= sel_addr;
            awsize  <= {1'b0, sel_size};
            wdata   <= sel_wdata;
            wstrb   <= sel_wstrb;
          end
        end
        W_SEND: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            w_state <= W_RESP;
            bready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            w_state <= W_IDLE;
            bready  <= 1'b0;
            wr_done <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb/tb_cpu_axi_bridge.sv - directed self-checking bench for cpu_axi_bridge
module tb_cpu_axi_bridge;
  localparam int NPORT = 2;
  localparam int ID_W  = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NPORT-1:0]  s_req, s_wr, s_addr_ok, s_data_ok;
  logic [2*NPORT-1:0]  s_size;
  logic [4*NPORT-1:0]  s_wstrb;
  logic [32*NPORT-1:0] s_addr, s_wdata;
  logic [31:0]       s_rdata;
  logic [ID_W-1:0]   arid, rid, awid, wid, bid;
  logic [31:0]       araddr, rdata, awaddr, wdata;
  logic [3:0]        arlen, arcache, awlen, awcache, wstrb;
  logic [2:0]        arsize, arprot, awsize, awprot;
  logic [1:0]        arburst, arlock, awburst, awlock, rresp, bresp;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  cpu_axi_bridge #(.NPORT(NPORT), .ID_W(ID_W), .RD_OUTS(4)) dut (
    .clk(clk), .resetn(resetn),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic [1:0]  exp_ok;
    logic [3:0]  exp_id;
    logic [2:0]  exp_size;
  } rd_vec_t;

  rd_vec_t vecs [4];
  int n_checks = 0;
  int n_pass   = 0;
  int grants;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd_req(input int p, input logic [31:0] a, input logic [1:0] sz);
    s_req[p] = 1'b1;
    s_wr[p]  = 1'b0;
    s_addr[32*p +: 32] = a;
    s_size[2*p +: 2]   = sz;
  endtask

  task automatic wr_req(input int p, input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
    s_req[p] = 1'b1;
    s_wr[p]  = 1'b1;
    s_addr[32*p +: 32]  = a;
    s_size[2*p +: 2]    = 2'd2;
    s_wstrb[4*p +: 4]   = st;
    s_wdata[32*p +: 32] = d;
  endtask

  task automatic count_grants(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (s_addr_ok[0]) n++;
      step();
    end
  endtask

  initial begin
    vecs[0] = '{0, 32'h1c00_0000, 2'd2, 32'h1234_5678, 2'b01, 4'd0, 3'd2};
    vecs[1] = '{1, 32'h0000_0abc, 2'd0, 32'hdead_beef, 2'b10, 4'd1, 3'd0};
    vecs[2] = '{1, 32'h1fc0_0002, 2'd1, 32'h0000_a5a5, 2'b10, 4'd1, 3'd1};
    vecs[3] = '{0, 32'h8000_0004, 2'd2, 32'hffff_ffff, 2'b01, 4'd0, 3'd2};

    resetn = 1'b0;
    s_req = 2'b11; s_wr = '0; s_size = '0; s_wstrb = '0; s_addr = '0; s_wdata = '0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;

    // Reset state, with requests asserted to show no accept while in reset
    step(); step(); #1;
    chk("rst_addr_ok", 32'(s_addr_ok), 32'd0);
    chk("rst_data_ok", 32'(s_data_ok), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("const_arburst", 32'(arburst), 32'd1);
    chk("const_arlen", 32'(arlen), 32'd0);
    chk("const_wlast", 32'(wlast), 32'd1);
    step();
    s_req = '0;
    resetn = 1'b1;

    // Single reads from each port
    for (int i = 0; i < 4; i++) begin
      step();
      rd_req(vecs[i].port, vecs[i].addr, vecs[i].size);
      arready = 1'b1;
      #1;
      chk("rd_addr_ok", 32'(s_addr_ok), 32'(vecs[i].exp_ok));
      step(); s_req = '0; #1;
      chk("rd_arvalid", 32'(arvalid), 32'd1);
      chk("rd_araddr", araddr, vecs[i].addr);
      chk("rd_arid", 32'(arid), 32'(vecs[i].exp_id));
      chk("rd_arsize", 32'(arsize), 32'(vecs[i].exp_size));
      step(); #1;
      chk("rd_arvalid_drop", 32'(arvalid), 32'd0);
      step();
      rvalid = 1'b1; rid = vecs[i].exp_id; rdata = vecs[i].rdata; #1;
      chk("rd_data_ok", 32'(s_data_ok), 32'(vecs[i].exp_ok));
      chk("rd_rdata", s_rdata, vecs[i].rdata);
      step(); rvalid = 1'b0; #1;
      chk("rd_data_ok_drop", 32'(s_data_ok), 32'd0);
    end

    // Simultaneous requests: port 1 first, port 0 only after the AR handshake
    step();
    arready = 1'b0;
    rd_req(0, 32'h0000_0100, 2'd2);
    rd_req(1, 32'h0000_0200, 2'd2);
    #1;
    chk("arb_first", 32'(s_addr_ok), 32'b10);
    step(); s_req[1] = 1'b0; #1;
    chk("arb_busy", 32'(s_addr_ok), 32'd0);
    chk("arb_arid1", 32'(arid), 32'd1);
    chk("arb_araddr1", araddr, 32'h0000_0200);
    arready = 1'b1;
    step(); #1;
    chk("arb_second", 32'(s_addr_ok), 32'b01);
    step(); s_req = '0; #1;
    chk("arb_arid0", 32'(arid), 32'd0);
    chk("arb_araddr0", araddr, 32'h0000_0100);
    step(); rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_1111; #1;
    chk("arb_data_ok1", 32'(s_data_ok), 32'b10);
    step(); rid = 4'd0; rdata = 32'h0000_2222; #1;
    chk("arb_data_ok0", 32'(s_data_ok), 32'b01);
    chk("arb_rdata0", s_rdata, 32'h0000_2222);
    step(); rvalid = 1'b0;

    // Outstanding limit: four accepted, fifth waits for a return
    rd_req(0, 32'h0000_2000, 2'd2);
    count_grants(12, grants);
    chk("outs_grants", 32'(grants), 32'd4);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_3333; #1;
    chk("outs_stall", 32'(s_addr_ok), 32'd0);
    chk("outs_ret_ok", 32'(s_data_ok), 32'b01);
    step(); rvalid = 1'b0; #1;
    chk("outs_fifth", 32'(s_addr_ok), 32'b01);
    step(); s_req = '0; rvalid = 1'b1; rid = 4'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("outs_drain", 32'(s_data_ok), 32'b01);
      step();
    end
    rvalid = 1'b0;

    // Write on port 1, W handshake three cycles after AW
    arready = 1'b0;
    wr_req(1, 32'h0000_0008, 4'b0011, 32'hcafe_f00d);
    #1;
    chk("wr_addr_ok", 32'(s_addr_ok), 32'b10);
    step(); s_req = '0; #1;
    chk("wr_awvalid", 32'(awvalid), 32'd1);
    chk("wr_wvalid", 32'(wvalid), 32'd1);
    chk("wr_awaddr", awaddr, 32'h0000_0008);
    chk("wr_wstrb", 32'(wstrb), 32'h3);
    chk("wr_wdata", wdata, 32'hcafe_f00d);
    chk("wr_awid", 32'(awid), 32'd1);
    chk("wr_wid", 32'(wid), 32'd1);
    chk("wr_awsize", 32'(awsize), 32'd2);
    awready = 1'b1;
    step(); awready = 1'b0; #1;
    chk("wr_aw_drop", 32'(awvalid), 32'd0);
    chk("wr_w_hold", 32'(wvalid), 32'd1);
    step(); step(); wready = 1'b1; #1;
    chk("wr_w_hold3", 32'(wvalid), 32'd1);
    chk("wr_no_bready", 32'(bready), 32'd0);
    step(); wready = 1'b0; #1;
    chk("wr_w_drop", 32'(wvalid), 32'd0);
    chk("wr_bready", 32'(bready), 32'd1);
    bvalid = 1'b1; bid = 4'd1; #1;
    chk("wr_no_early_ok", 32'(s_data_ok), 32'd0);
    step(); bvalid = 1'b0; #1;
    chk("wr_data_ok", 32'(s_data_ok), 32'b10);
    step(); #1;
    chk("wr_data_ok_drop", 32'(s_data_ok), 32'd0);

    // Write blocked by pending read; read blocked during W_RESP
    arready = 1'b1;
    rd_req(1, 32'h0000_0300, 2'd2); #1;
    chk("ord_rd_ok", 32'(s_addr_ok), 32'b10);
    step(); wr_req(1, 32'h0000_0040, 4'hf, 32'h5555_aaaa); #1;
    chk("ord_wr_blk_arv", 32'(s_addr_ok), 32'd0);
    step(); #1;
    chk("ord_wr_blk_cnt", 32'(s_addr_ok), 32'd0);
    step(); rvalid = 1'b1; rid = 4'd1; #1;
    chk("ord_rd_ret", 32'(s_data_ok), 32'b10);
    chk("ord_wr_blk_ret", 32'(s_addr_ok), 32'd0);
    step(); rvalid = 1'b0; awready = 1'b1; wready = 1'b1; #1;
    chk("ord_wr_ok", 32'(s_addr_ok), 32'b10);
    step(); s_req = '0; #1;
    chk("ord_aw_w_both", 32'({awvalid, wvalid}), 32'b11);
    step(); rd_req(0, 32'h0000_0500, 2'd2); #1;
    chk("ord_bready", 32'(bready), 32'd1);
    chk("ord_rd_blk_resp", 32'(s_addr_ok), 32'd0);
    step(); bvalid = 1'b1; #1;
    chk("ord_rd_blk_b", 32'(s_addr_ok), 32'd0);
    step(); bvalid = 1'b0; #1;
    chk("ord_wr_done", 32'(s_data_ok), 32'b10);
    chk("ord_rd_after_b", 32'(s_addr_ok), 32'b01);
    step(); s_req = '0; awready = 1'b0; wready = 1'b0; #1;
    chk("ord_arid", 32'(arid), 32'd0);
    step(); rvalid = 1'b1; rid = 4'd0; #1;
    chk("ord_rd0_ret", 32'(s_data_ok), 32'b01);
    step(); rvalid = 1'b0;

    // Async reset with an AR in flight and two reads outstanding
    arready = 1'b1;
    rd_req(0, 32'h0000_0600, 2'd2); #1;
    chk("rst_seq_ok1", 32'(s_addr_ok), 32'b01);
    step(); s_req = '0;
    step(); arready = 1'b0; rd_req(0, 32'h0000_0604, 2'd2); #1;
    chk("rst_seq_ok2", 32'(s_addr_ok), 32'b01);
    step(); #1;
    chk("rst_seq_arvalid", 32'(arvalid), 32'd1);
    #1; resetn = 1'b0; #1;
    chk("rst_async_arvalid", 32'(arvalid), 32'd0);
    chk("rst_async_rready", 32'(rready), 32'd0);
    chk("rst_async_addr_ok", 32'(s_addr_ok), 32'd0);
    step(); step(); resetn = 1'b1; arready = 1'b1; #1;
    chk("rst_rel_addr_ok", 32'(s_addr_ok), 32'd0);
    step();
    count_grants(12, grants);
    chk("rst_fresh_grants", 32'(grants), 32'd4);
    s_req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
